// File: rtl/retire_stage_pkg.sv
// Shared constants and FSM encoding for the two-wide retirement stage.
package retire_stage_pkg;

    localparam int XLEN_DEF     = 64;
    localparam int REG_W_DEF    = 5;
    localparam int ZERO_REG_DEF = 31;
    localparam int ROB_ENTRIES  = 32;

    // RUN: retiring normally; FLUSH: one-cycle redirect pulse; HALTED: sticky stop.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_HALTED = 2'd2
    } retire_state_t;

endpackage

// File: rtl/retire_stage_if.sv
// Bundle between the ROB head window and the retirement stage, plus the
// retirement results going to the register file and front end.
//
// Handshake: a head slot is offered when head_valid[s] is set and is ready to
// leave when head_complete[s] is also set. The stage answers in the same cycle
// with rob_retire_count; the ROB pops exactly that many entries on the next
// rising edge. Slots beyond the retiring ones are ignored entirely.
interface retire_stage_if #(
    parameter int XLEN  = 64,
    parameter int REG_W = 5
);
    logic [1:0]       head_valid;
    logic [1:0]       head_complete;
    logic [REG_W-1:0] head_dest_reg0;
    logic [REG_W-1:0] head_dest_reg1;
    logic [XLEN-1:0]  head_value0;
    logic [XLEN-1:0]  head_value1;
    logic [1:0]       head_mispredict;
    logic [63:0]      head_target_pc0;
    logic [63:0]      head_target_pc1;
    logic [1:0]       head_halt;

    logic [1:0]       rob_retire_count;
    logic             rf_we0;
    logic             rf_we1;
    logic [REG_W-1:0] rf_waddr0;
    logic [REG_W-1:0] rf_waddr1;
    logic [XLEN-1:0]  rf_wdata0;
    logic [XLEN-1:0]  rf_wdata1;
    logic             flush;
    logic [63:0]      flush_pc;
    logic             halted;
    logic [63:0]      retired_total;

    // ROB side: presents head entries, consumes retirement results.
    modport master (
        output head_valid, head_complete, head_dest_reg0, head_dest_reg1,
               head_value0, head_value1, head_mispredict,
               head_target_pc0, head_target_pc1, head_halt,
        input  rob_retire_count, rf_we0, rf_we1, rf_waddr0, rf_waddr1,
               rf_wdata0, rf_wdata1, flush, flush_pc, halted, retired_total
    );

    // Retirement stage side.
    modport slave (
        input  head_valid, head_complete, head_dest_reg0, head_dest_reg1,
               head_value0, head_value1, head_mispredict,
               head_target_pc0, head_target_pc1, head_halt,
        output rob_retire_count, rf_we0, rf_we1, rf_waddr0, rf_waddr1,
               rf_wdata0, rf_wdata1, flush, flush_pc, halted, retired_total
    );

endinterface

// File: rtl/retire_stage_select.sv
// Combinational per-slot retire eligibility, retire count and event detection.
module retire_select (
    input  logic       en_i,
    input  logic [1:0] valid_i,
    input  logic [1:0] complete_i,
    input  logic [1:0] mispredict_i,
    input  logic [1:0] halt_i,
    output logic [1:0] retire_o,
    output logic [1:0] count_o,
    output logic       redirect_o,
    output logic       redirect_slot_o,
    output logic       halt_o
);

    logic r0;
    logic r1;

    // Slot 1 may only follow a clean slot 0, so at most one slot carries an event.
    always_comb begin
        r0              = en_i & valid_i[0] & complete_i[0];
        r1              = r0 & valid_i[1] & complete_i[1]
                        & ~mispredict_i[0] & ~halt_i[0];
        retire_o        = {r1, r0};
        count_o         = {1'b0, r0} + {1'b0, r1};
        halt_o          = |({r1, r0} & halt_i);
        // Halt outranks mispredict on the same slot: no redirect then.
        redirect_o      = |({r1, r0} & mispredict_i & ~halt_i);
        // If slot 1 retired, slot 0 was clean, so any redirect came from slot 1.
        redirect_slot_o = r1;
    end

endmodule

// File: rtl/retire_stage.sv
// Two-wide in-order retirement: decides retire count combinationally, writes
// the register file one cycle later, and drives flush/halt control.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int REG_W    = REG_W_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic          clock,
    input  logic          reset,
    retire_stage_if.slave rob,
    output retire_state_t dbg_state_o
);

    localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

    retire_state_t    state_q;
    logic             rf_we0_q, rf_we1_q;
    logic [REG_W-1:0] rf_waddr0_q, rf_waddr1_q;
    logic [XLEN-1:0]  rf_wdata0_q, rf_wdata1_q;
    logic             flush_q;
    logic [63:0]      flush_pc_q;
    logic             halted_q;
    logic [63:0]      retired_total_q;

    logic             sel_en;
    logic [1:0]       retire;
    logic [1:0]       count;
    logic             redirect;
    logic             redirect_slot;
    logic             halt_hit;
    logic             rf_we0_d, rf_we1_d;
    logic [63:0]      redirect_pc;

    // Retirement only happens in RUN and never while reset is held.
    assign sel_en = reset & (state_q == ST_RUN);

    retire_select u_select (
        .en_i            (sel_en),
        .valid_i         (rob.head_valid),
        .complete_i      (rob.head_complete),
        .mispredict_i    (rob.head_mispredict),
        .halt_i          (rob.head_halt),
        .retire_o        (retire),
        .count_o         (count),
        .redirect_o      (redirect),
        .redirect_slot_o (redirect_slot),
        .halt_o          (halt_hit)
    );

    assign rf_we0_d    = retire[0] & (rob.head_dest_reg0 != ZR);
    assign rf_we1_d    = retire[1] & (rob.head_dest_reg1 != ZR);
    assign redirect_pc = redirect_slot ? rob.head_target_pc1 : rob.head_target_pc0;

    // FSM and all registered retirement outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            rf_we0_q        <= 1'b0;
            rf_we1_q        <= 1'b0;
            rf_waddr0_q     <= '0;
            rf_waddr1_q     <= '0;
            rf_wdata0_q     <= '0;
            rf_wdata1_q     <= '0;
            flush_q         <= 1'b0;
            flush_pc_q      <= '0;
            halted_q        <= 1'b0;
            retired_total_q <= '0;
        end else begin
            rf_we0_q        <= rf_we0_d;
            rf_we1_q        <= rf_we1_d;
            // Address/data only move on a real write so idle slots leave no trace.
            if (rf_we0_d) begin
                rf_waddr0_q <= rob.head_dest_reg0;
                rf_wdata0_q <= rob.head_value0;
            end
            if (rf_we1_d) begin
                rf_waddr1_q <= rob.head_dest_reg1;
                rf_wdata1_q <= rob.head_value1;
            end
            retired_total_q <= retired_total_q + 64'(count);
            flush_q         <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (halt_hit) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else if (redirect) begin
                        state_q    <= ST_FLUSH;
                        flush_q    <= 1'b1;
                        flush_pc_q <= redirect_pc;
                    end
                end
                ST_FLUSH:  state_q <= ST_RUN;
                ST_HALTED: state_q <= ST_HALTED;
                default:   state_q <= ST_RUN;
            endcase
        end
    end

    assign rob.rob_retire_count = count;
    assign rob.rf_we0           = rf_we0_q;
    assign rob.rf_we1           = rf_we1_q;
    assign rob.rf_waddr0        = rf_waddr0_q;
    assign rob.rf_waddr1        = rf_waddr1_q;
    assign rob.rf_wdata0        = rf_wdata0_q;
    assign rob.rf_wdata1        = rf_wdata1_q;
    assign rob.flush            = flush_q;
    assign rob.flush_pc         = flush_pc_q;
    assign rob.halted           = halted_q;
    assign rob.retired_total    = retired_total_q;
    assign dbg_state_o          = state_q;

endmodule

// File: tb/tb_retire_stage.sv
// Scoreboard bench for retire_stage: a ROB-walking reference model pushes
// expected outputs, a negedge monitor pops and compares them.
module tb_retire_stage;
    import retire_stage_pkg::*;

    typedef struct {
        int cyc;
        int n;
    } cnt_exp_t;

    typedef struct {
        int          cyc;
        logic        we0, we1;
        logic [4:0]  a0, a1;
        logic [63:0] d0, d1;
        logic        fl;
        logic [63:0] fpc;
        logic        hl;
        logic [63:0] tot;
    } reg_exp_t;

    logic          clock;
    logic          reset;
    retire_state_t dbg_state;
    int            cyc;
    int            n_checks;
    int            n_fail;

    cnt_exp_t      cnt_q[$];
    reg_exp_t      reg_q[$];

    // Reference model state
    bit            m_halted;
    bit            m_flush;
    logic [63:0]   m_total;
    logic [63:0]   mdl_rf[32];
    logic [63:0]   obs_rf[32];

    retire_stage_if #(.XLEN(64), .REG_W(5)) bus ();

    retire_stage dut (
        .clock       (clock),
        .reset       (reset),
        .rob         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Driver: apply one cycle of head inputs, run the model, push expectations.
    task automatic drive(input logic [1:0] v, input logic [1:0] c,
                         input logic [1:0] mp, input logic [1:0] h,
                         input logic [4:0] d0, input logic [4:0] d1,
                         input logic [63:0] x0, input logic [63:0] x1,
                         input logic [63:0] t0, input logic [63:0] t1);
        logic [4:0]  dst[2];
        logic [63:0] val[2];
        logic [63:0] tgt[2];
        int          n;
        bit          fl_next;
        cnt_exp_t    ce;
        reg_exp_t    e;
        bus.head_valid      = v;
        bus.head_complete   = c;
        bus.head_mispredict = mp;
        bus.head_halt       = h;
        bus.head_dest_reg0  = d0;
        bus.head_dest_reg1  = d1;
        bus.head_value0     = x0;
        bus.head_value1     = x1;
        bus.head_target_pc0 = t0;
        bus.head_target_pc1 = t1;
        dst[0] = d0; dst[1] = d1;
        val[0] = x0; val[1] = x1;
        tgt[0] = t0; tgt[1] = t1;
        n = 0;
        fl_next = 0;
        e = '{cyc: cyc + 1, we0: 0, we1: 0, a0: 0, a1: 0, d0: 0, d1: 0,
              fl: 0, fpc: 0, hl: 0, tot: 0};
        if (!m_halted && !m_flush) begin
            // Walk the ROB head oldest-first; stop at the first entry that
            // cannot leave, or right after a halting/mispredicting one.
            for (int s = 0; s < 2; s++) begin
                if (!(v[s] && c[s])) break;
                n++;
                if (dst[s] != 5'd31) begin
                    if (s == 0) begin e.we0 = 1; e.a0 = dst[s]; e.d0 = val[s]; end
                    else        begin e.we1 = 1; e.a1 = dst[s]; e.d1 = val[s]; end
                    mdl_rf[dst[s]] = val[s];
                end
                if (h[s]) begin
                    m_halted = 1;
                    break;
                end
                if (mp[s]) begin
                    fl_next = 1;
                    e.fpc   = tgt[s];
                    break;
                end
            end
        end
        m_flush  = fl_next;
        m_total  = m_total + 64'(n);
        e.fl     = fl_next;
        e.hl     = m_halted;
        e.tot    = m_total;
        ce.cyc   = cyc;
        ce.n     = n;
        cnt_q.push_back(ce);
        reg_q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic drive_rand(input int mp_pct, input int h_pct);
        logic [1:0] mp, h;
        mp[0] = ($urandom_range(99) < mp_pct);
        mp[1] = ($urandom_range(99) < mp_pct);
        h[0]  = ($urandom_range(99) < h_pct);
        h[1]  = ($urandom_range(99) < h_pct);
        drive(2'($urandom_range(3)), 2'($urandom_range(3)), mp, h,
              5'($urandom_range(31)), 5'($urandom_range(31)),
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    endtask

    // Reset: clears pending expectations and model, checks async values.
    task automatic do_reset();
        bus.head_valid    = 2'b11;
        bus.head_complete = 2'b11;
        reset = 1'b0;
        cnt_q.delete();
        reg_q.delete();
        m_halted = 0;
        m_flush  = 0;
        m_total  = '0;
        #1;
        chk("rst_count",  bus.rob_retire_count, 2'd0);
        chk("rst_we",     {bus.rf_we0, bus.rf_we1}, 2'b00);
        chk("rst_waddr",  {bus.rf_waddr0, bus.rf_waddr1}, 10'd0);
        chk("rst_wdata",  bus.rf_wdata0 | bus.rf_wdata1, 64'd0);
        chk("rst_flush",  {bus.flush, bus.halted}, 2'b00);
        chk("rst_fpc",    bus.flush_pc, 64'd0);
        chk("rst_total",  bus.retired_total, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: compare whatever expectations are due this cycle.
    always @(negedge clock) begin
        if (reset) begin
            while (cnt_q.size() > 0 && cnt_q[0].cyc < cyc) begin
                chk("count_missed", 64'(cnt_q[0].cyc), 64'(cyc));
                void'(cnt_q.pop_front());
            end
            if (cnt_q.size() > 0 && cnt_q[0].cyc == cyc) begin
                chk("retire_count", bus.rob_retire_count, 64'(cnt_q[0].n));
                void'(cnt_q.pop_front());
            end
            while (reg_q.size() > 0 && reg_q[0].cyc < cyc) begin
                chk("reg_missed", 64'(reg_q[0].cyc), 64'(cyc));
                void'(reg_q.pop_front());
            end
            if (reg_q.size() > 0 && reg_q[0].cyc == cyc) begin
                chk("rf_we0", bus.rf_we0, reg_q[0].we0);
                chk("rf_we1", bus.rf_we1, reg_q[0].we1);
                if (reg_q[0].we0) begin
                    chk("rf_waddr0", bus.rf_waddr0, reg_q[0].a0);
                    chk("rf_wdata0", bus.rf_wdata0, reg_q[0].d0);
                end
                if (reg_q[0].we1) begin
                    chk("rf_waddr1", bus.rf_waddr1, reg_q[0].a1);
                    chk("rf_wdata1", bus.rf_wdata1, reg_q[0].d1);
                end
                chk("flush", bus.flush, reg_q[0].fl);
                if (reg_q[0].fl) chk("flush_pc", bus.flush_pc, reg_q[0].fpc);
                chk("halted", bus.halted, reg_q[0].hl);
                chk("retired_total", bus.retired_total, reg_q[0].tot);
                void'(reg_q.pop_front());
            end
            // Architectural RF as seen from the write ports; port 1 wins.
            if (bus.rf_we0) obs_rf[bus.rf_waddr0] = bus.rf_wdata0;
            if (bus.rf_we1) obs_rf[bus.rf_waddr1] = bus.rf_wdata1;
        end
    end

    initial begin
        int w;
        n_checks = 0;
        n_fail   = 0;
        m_total  = '0;
        for (int i = 0; i < 32; i++) begin
            mdl_rf[i] = '0;
            obs_rf[i] = '0;
        end
        reset = 1'b0;
        idle_inputs();
        #1;
        do_reset();

        // Dual retire r3=0x11, r4=0x22
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd3, 5'd4, 64'h11, 64'h22, 64'h0, 64'h0);
        idle();
        // Head incomplete, head+1 complete: nothing retires
        drive(2'b11, 2'b10, 2'b00, 2'b00, 5'd8, 5'd9, 64'h33, 64'h44, 64'h0, 64'h0);
        // Slot 0 mispredict to 0x400; FLUSH cycle ignores valid input; then RUN
        drive(2'b11, 2'b11, 2'b01, 2'b00, 5'd6, 5'd7, 64'h55, 64'h66, 64'h400, 64'h800);
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd10, 5'd11, 64'h77, 64'h88, 64'h0, 64'h0);
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd12, 5'd13, 64'h99, 64'haa, 64'h0, 64'h0);
        // Slot 1 mispredict with clean slot 0
        drive(2'b11, 2'b11, 2'b10, 2'b00, 5'd14, 5'd15, 64'h1, 64'h2, 64'h500, 64'h600);
        idle();
        // Same register from both slots: younger value must survive
        drive(2'b11, 2'b11, 2'b00, 2'b00, 5'd5, 5'd5, 64'hA, 64'hB, 64'h0, 64'h0);
        idle();
        idle();
        chk("rf_r5_final", obs_rf[5], 64'hB);
        // Halt and mispredict on slot 0 together: halt wins, no flush
        drive(2'b11, 2'b11, 2'b01, 2'b01, 5'd20, 5'd21, 64'hC, 64'hD, 64'h900, 64'h0);
        idle();
        do_reset();
        // Slot 1 halt, dests 31 and 7, then sticky for 10 valid cycles
        drive(2'b11, 2'b11, 2'b00, 2'b10, 5'd31, 5'd7, 64'hE, 64'hF, 64'h0, 64'h0);
        for (int i = 0; i < 10; i++) drive_rand(0, 0);
        do_reset();
        // Async reset inside the FLUSH cycle
        drive(2'b01, 2'b01, 2'b01, 2'b00, 5'd2, 5'd2, 64'h3, 64'h0, 64'h700, 64'h0);
        bus.head_valid    = 2'b11;
        bus.head_complete = 2'b11;
        #1;
        chk("flush_before_rst", bus.flush, 1'b1);
        cnt_q.delete();
        reg_q.delete();
        reset = 1'b0;
        #1;
        chk("flush_async_drop", bus.flush, 1'b0);
        do_reset();
        idle();
        idle();

        // Random blocks, reset between them so a halt does not end the run
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 50; i++) drive_rand(12, 3);
            idle();
            do_reset();
        end
        for (int i = 0; i < 40; i++) drive_rand(10, 0);
        idle();

        // Drain with a bounded wait
        w = 0;
        while ((cnt_q.size() > 0 || reg_q.size() > 0) && w < 20) begin
            @(posedge clock);
            w++;
        end
        chk("drain_empty", 64'(cnt_q.size() + reg_q.size()), 64'd0);
        #1;
        for (int i = 0; i < 32; i++) chk("rf_contents", obs_rf[i], mdl_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    task automatic idle_inputs();
        bus.head_valid      = 2'b00;
        bus.head_complete   = 2'b00;
        bus.head_mispredict = 2'b00;
        bus.head_halt       = 2'b00;
        bus.head_dest_reg0  = '0;
        bus.head_dest_reg1  = '0;
        bus.head_value0     = '0;
        bus.head_value1     = '0;
        bus.head_target_pc0 = '0;
        bus.head_target_pc1 = '0;
    endtask

endmodule

// File: doc/retire_stage.md
# retire_stage

Two-wide in-order retirement stage directly downstream of the 32-entry reorder buffer. Each cycle it examines the two oldest ROB entries (head and head+1) and decides combinationally how many retire, so the ROB can advance its head on the same edge. It writes retired results to the architectural register file one cycle later. It raises a one-cycle pipeline flush on a retired branch mispredict and parks in a sticky halted state on a retired halt or illegal instruction.

## Interface
- `XLEN`, default 64: retired value width.
- `REG_W`, default 5: architectural register index width.
- `ZERO_REG`, default 31: destination index that is never written.
- `clock` in 1: single clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `head_valid` in 2: bit0 = ROB head entry occupied; bit1 = head+1 entry occupied.
- `head_complete` in 2: per-slot "result written back".
- `head_dest_reg0`, `head_dest_reg1` in REG_W: per-slot destination register.
- `head_value0`, `head_value1` in XLEN: per-slot result.
- `head_mispredict` in 2: per-slot "resolved branch was mispredicted".
- `head_target_pc0`, `head_target_pc1` in 64: per-slot correct next PC.
- `head_halt` in 2: per-slot halt or illegal-instruction marker.
- `rob_retire_count` out 2: combinational, 0..2; the ROB advances its head by this amount on the next edge.
- `rf_we0`, `rf_we1` out 1: registered architectural RF write enables.
- `rf_waddr0`, `rf_waddr1` out REG_W: registered RF write addresses.
- `rf_wdata0`, `rf_wdata1` out XLEN: registered RF write data.
- `flush` out 1: registered one-cycle pulse; clears ROB, reservation stations and fetch.
- `flush_pc` out 64: registered redirect PC, valid while `flush`=1.
- `halted` out 1: registered, sticky.
- `retired_total` out 64: registered count of retired instructions.

## Operation
- FSM states: RUN, FLUSH, HALTED.
- RUN, slot 0 retires when `head_valid[0] & head_complete[0]`.
- RUN, slot 1 retires only if slot 0 retires, `head_valid[1] & head_complete[1]` is set, and slot 0 has neither mispredict nor halt.
- `rob_retire_count` is the number of retiring slots. It is 0 in FLUSH, in HALTED, and while reset is asserted.
- Each retiring slot with dest != ZERO_REG produces an RF write on the next edge; a slot with dest == ZERO_REG retires with `rf_we`=0. When both slots write the same register, slot 1 is younger, and the RF gives port 1 priority.
- A retiring slot with mispredict (slot 0, or slot 1 when slot 0 is clean) sets `flush_pc` to that slot's target PC and moves RUN->FLUSH. The `flush` pulse is driven during FLUSH. FLUSH->RUN after exactly one cycle.
- A retiring slot with halt moves RUN->HALTED. The halting instruction counts as retired and writes its destination if it has one. HALTED is left only by reset.
- When halt and mispredict are set on the same slot, halt wins and no flush is issued.
- `retired_total` += `rob_retire_count` each edge, wrapping modulo 2^64.
- Non-retiring slots must not affect any output; their inputs are don't-care.

## Timing
- Retire decision: 0-cycle combinational from head inputs to `rob_retire_count`.
- RF write: 1 cycle after the retire edge.
- Flush: `flush`=1 during the cycle after the mispredicting retire. During that cycle `rob_retire_count`=0 regardless of inputs, the ROB is cleared at its end, and RUN resumes on the following cycle.
- Reset (async, any time, including mid-FLUSH or with RF writes pending): state=RUN; all `rf_we`=0; `rf_waddr`=0; `rf_wdata`=0; `flush`=0; `flush_pc`=0; `halted`=0; `retired_total`=0; any pending write or flush is dropped.
- Empty ROB (`head_valid`=0): count 0, state unchanged.
- Head incomplete while head+1 is complete: count 0, so retirement stays strictly in order.
- ROB index wrap-around is the ROB's concern; this stage sees only slot-relative inputs.

## Structure
- Shared package: FSM state encoding (RUN/FLUSH/HALTED), `ZERO_REG`, and the XLEN/REG_W constants, together with ROB_ENTRIES = 32.
- One sub-module, `retire_select`: purely combinational per-slot eligibility and count logic. The top level holds the FSM and output registers.

## Test plan
- Head slots both valid+complete, dests 3 and 4, values 0x11 and 0x22 -> count=2; next cycle `rf_we0`/`rf_we1`=1 writing r3=0x11 and r4=0x22; `retired_total`=2.
- Slot 0 incomplete, slot 1 complete -> count=0, no RF write, no state change.
- Slot 0 mispredict with target 0x400, slot 1 complete -> count=1; next cycle `flush`=1, `flush_pc`=0x400, count=0 despite valid inputs; RUN resumes the cycle after.
- Slot 1 halt, slot 0 clean, dests 31 and 7 -> count=2; `rf_we0`=0 and `rf_we1`=1 (r7); `halted`=1 and remains 1 with count=0 for 10 further cycles of valid input.
- Reset asserted during the FLUSH cycle -> `flush` drops immediately (async); after release: RUN, `retired_total`=0, no write emitted.
- Both slots write r5 with 0xA then 0xB -> both write enables set; the RF ends holding 0xB.
